// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants, coordinate type and range helper.
// Consumed by vga_sync_gen and pixel_tick_gen.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int CLK_DIV = 4;

  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_DISP + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISP + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Mod-CLK_DIV divider producing a one-clk pixel enable every CLK_DIV clks.
// The first enable after reset release appears once the divider reaches CLK_DIV-1.
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, registered active-low syncs, video_on.
// Define VGA_FRAME_CNT_EN to add an 8-bit wrapping frame counter output (frame_cnt).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
  parameter int H_DISP  = vga_timing_pkg::H_DISP,
  parameter int H_FP    = vga_timing_pkg::H_FP,
  parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
  parameter int H_BP    = vga_timing_pkg::H_BP,
  parameter int V_DISP  = vga_timing_pkg::V_DISP,
  parameter int V_FP    = vga_timing_pkg::V_FP,
  parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
  parameter int V_BP    = vga_timing_pkg::V_BP
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]         frame_cnt
`endif
);

  localparam coord_t H_VIS  = coord_t'(H_DISP);
  localparam coord_t H_LAST = coord_t'(H_DISP + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t H_SS   = coord_t'(H_DISP + H_FP);
  localparam coord_t H_SE   = coord_t'(H_DISP + H_FP + H_SYNC - 1);
  localparam coord_t V_VIS  = coord_t'(V_DISP);
  localparam coord_t V_LAST = coord_t'(V_DISP + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t V_SS   = coord_t'(V_DISP + V_FP);
  localparam coord_t V_SE   = coord_t'(V_DISP + V_FP + V_SYNC - 1);

  coord_t pix_x_q, pix_x_d;
  coord_t pix_y_q, pix_y_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .p_tick(p_tick)
  );

  // Syncs decode the next-state counters so they land in the same cycle as pix_x/pix_y.
  always_comb begin
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    if (p_tick) begin
      if (pix_x_q == H_LAST) begin
        pix_x_d = '0;
        pix_y_d = (pix_y_q == V_LAST) ? '0 : pix_y_q + 1'b1;
      end else begin
        pix_x_d = pix_x_q + 1'b1;
      end
    end
    hsync_d = !in_range(pix_x_d, H_SS, H_SE);
    vsync_d = !in_range(pix_y_d, V_SS, V_SE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x_q <= '0;
      pix_y_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pix_x    = pix_x_q;
  assign pix_y    = pix_y_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign video_on = (pix_x_q < H_VIS) && (pix_y_q < V_VIS);

`ifdef VGA_FRAME_CNT_EN
  logic       frame_wrap;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  assign frame_wrap = p_tick && (pix_x_q == H_LAST) && (pix_y_q == V_LAST);

  always_comb begin
    frame_cnt_d = frame_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates 640x480@60 Hz VGA timing for the display pipeline.
- Produces the pixel-rate enable, the pixel coordinates pix_x/pix_y, registered hsync/vsync and video_on.
- Sits directly upstream of the text-overlay stage (Iniciales), which consumes pix_x/pix_y, and of the RGB output mux, which consumes video_on.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2.
- H_DISP, 640, visible pixels per line.
- H_FP, 16, horizontal front porch.
- H_SYNC, 96, horizontal sync width.
- H_BP, 48, horizontal back porch.
- V_DISP, 480, visible lines.
- V_FP, 10, vertical front porch.
- V_SYNC, 2, vertical sync width.
- V_BP, 33, vertical back porch.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous reset, active-high.
- p_tick  out  1  pixel enable; high for one clk every CLK_DIV clks.
- pix_x  out  10  horizontal counter, 0..799.
- pix_y  out  10  vertical counter, 0..524.
- hsync  out  1  horizontal sync, active-low, registered.
- vsync  out  1  vertical sync, active-low, registered.
- video_on  out  1  high when pix_x < H_DISP and pix_y < V_DISP.

Behaviour:
- Reset values (sampled on a rising clk with reset=1):
  - divider = 0, p_tick = 0
  - pix_x = 0, pix_y = 0
  - hsync = 1, vsync = 1
  - video_on = 1, since it is combinational from the counters at (0,0).
- Divider:
  - Mod-CLK_DIV counter.
  - p_tick = 1 when divider == CLK_DIV-1; the first p_tick after reset release occurs on the CLK_DIV-th clk.
- Counters advance only on clks where p_tick = 1:
  - pix_x increments.
  - At H_TOTAL-1 (799), pix_x wraps to 0 and pix_y increments.
  - When pix_x = 799 and pix_y = V_TOTAL-1 (524) on the same tick, both wrap to 0.
  - pix_y never exceeds 524 and pix_x never exceeds 799; no other states are reachable.
  - H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL is the analogous vertical sum.
- hsync/vsync:
  - Registered from the next-state counter values, so they are aligned in the same cycle as pix_x/pix_y with zero relative latency.
  - hsync = 0 iff pix_x in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] = [656, 751].
  - vsync = 0 iff pix_y in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1] = [490, 491].
- video_on: combinational from pix_x/pix_y; 0 during porches and sync.
- Between ticks all outputs except p_tick hold their values.
- Reset mid-frame: on the next clk, all state returns to its reset values regardless of divider phase; no partial line completes.
- Arithmetic: 10-bit unsigned; comparisons use constants derived from the parameters.
- Period checks: a line is 800*CLK_DIV = 3200 clks; a frame is 525 lines = 1 680 000 clks.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt (8 bits, reset 0).
  - frame_cnt increments on the p_tick where pix_x=799 and pix_y=524 (frame wrap), and wraps 255 -> 0.
  - Used by downstream overlays for blink and animation timing.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - The timing constants listed under Parameters, plus H_TOTAL and V_TOTAL.
  - The derived sync start/end constants.
  - The coordinate width (10).
- Sub-module pixel_tick_gen holds the mod-CLK_DIV divider.
  - Ports: clk, reset, p_tick.
  - Reusable by other stages that need the pixel enable.

Test Plan:
- Reset held 3 clks, then released -> p_tick is first high on the 4th clk after release; pix_x=0, pix_y=0, hsync=1, vsync=1, video_on=1.
- Run 656 ticks -> hsync goes 0 in the same cycle pix_x becomes 656, returns to 1 at pix_x=752; video_on=0 from pix_x=640.
- Run to pix_x=799, pix_y=0, then one tick -> pix_x=0, pix_y=1; measured line period = 3200 clks.
- Run to pix_y=490 -> vsync=0 for exactly 2 lines (1600 ticks); at pix_x=799, pix_y=524, next tick -> both 0; measured frame period = 1 680 000 clks.
- Assert reset at pix_x=300, pix_y=200 with divider=2 -> next clk: all outputs at reset values; first post-release p_tick after 4 clks.
- With VGA_FRAME_CNT_EN defined, run 257 frames -> frame_cnt steps 0->1 at the first wrap, reaches 255, then wraps to 0, then 1.
